lavadora_param: RTL
===================

# lavadora_param

Parametrised successor to the coin-operated washer controller. It accumulates coins of arbitrary value into a saturating credit register and, on payment completion, selects the most expensive affordable service. It returns change, then runs timed wash/dry phases with cycle-exact durations before returning to idle. It sits between the coin acceptor front end and the motor/heater drivers, and is exercised by the same tester/testbench pair style as the existing washer.

## Interface
- W_CRED, 8: credit/coin value width in bits.
- W_T, 16: phase timer width.
- P_SECADO, 2: price of dry-only service.
- P_LAVADO, 4: price of wash+dry.
- P_PESADO, 6: price of heavy wash+dry. Must satisfy 0 < P_SECADO < P_LAVADO < P_PESADO < 2^W_CRED.
- T_SECADO, 8; T_LAVADO, 10; T_PESADO, 16: phase durations in clock cycles, each ≥ 1 and < 2^W_T.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- intro_moneda  in  1  one-cycle strobe, coin present.
- valor_moneda  in  W_CRED  value of coin, sampled with intro_moneda.
- finalizar_pago  in  1  one-cycle strobe, payment complete.
- lavado  out  1  normal wash phase active.
- lavado_pesado  out  1  heavy wash phase active.
- secado  out  1  dry phase active.
- insuficiente  out  1  one-cycle pulse, credit below P_SECADO at finalize.
- vuelto  out  W_CRED  change/refund value, valid with vuelto_valido.
- vuelto_valido  out  1  one-cycle pulse.
- ocupado  out  1  high in any non-idle state.
- fin  out  1  one-cycle pulse when the service completes.

## Operation
- States: COBRO, LAVADO, PESADO, SECADO, FIN.
- Reset (reset=0 at an edge) puts the FSM in COBRO, clears credit and timer, and drives all outputs to 0. This applies mid-service too: the phase is aborted and the credit is lost.
- COBRO:
  - intro_moneda adds valor_moneda to credit.
  - If the sum exceeds 2^W_CRED−1, the credit is unchanged and the coin is refunded: vuelto=valor_moneda, vuelto_valido=1.
  - A coin of value 0 is ignored.
- finalizar_pago in COBRO selects the service, highest first:
  - credit ≥ P_PESADO → PESADO, change = credit−P_PESADO.
  - else credit ≥ P_LAVADO → LAVADO, change = credit−P_LAVADO.
  - else credit ≥ P_SECADO → SECADO, change = credit−P_SECADO.
  - else: stay in COBRO, pulse insuficiente, keep the credit.
- On service selection, credit is cleared and vuelto_valido pulses, even if the change is 0.
- Simultaneous intro_moneda and finalizar_pago: the coin is added first, and the selection uses the updated credit. An overflow-refunded coin is excluded from the selection. If this refund coincides with a change pulse, the refund is the one dropped; the coin is kept in credit only if it fits.
- LAVADO and PESADO each run their T, then go to SECADO. SECADO runs T_SECADO, then goes to FIN. FIN lasts one cycle with fin=1, then returns to COBRO.
- Service phases:
  - intro_moneda is refunded (vuelto=valor_moneda, vuelto_valido=1).
  - finalizar_pago is ignored.
- Exactly one of lavado/lavado_pesado/secado is high during its phase. All three are low in COBRO and FIN.

## Timing
- All outputs are registered.
- finalize sampled at edge N: the phase output and the vuelto_valido pulse are high from N+1.
- A phase output stays high for exactly T cycles. The next phase output rises in the cycle after the previous one falls, with no gap and no overlap.
- fin is high for one cycle directly after the last secado cycle. ocupado is high from N+1 through the fin cycle inclusive.
- insuficiente and the coin-refund pulses appear the cycle after the triggering strobe.
- Credit update latency: a coin at edge N is visible to a finalize at edge N+1.

## Structure
- Package lavadora_pkg holds:
  - the state enum (COBRO, LAVADO, PESADO, SECADO, FIN);
  - a service-select function, credit → {state, change}.
- Sub-module contador_fase (W_T): load value, decrement, terminal-count flag. It is instantiated once and reloaded at each phase entry.
- Top module holds the FSM, the credit register and the output registers.

## Test plan
- Coins 2+2, finalize → lavado high 10 cycles, secado 8, fin pulse; vuelto=0 with valid.
- Coins 5+3, finalize → lavado_pesado 16 cycles, then secado 8; vuelto=2.
- Coin 1, finalize → insuficiente pulse, state COBRO; add coin 1, finalize → secado 8 cycles, vuelto=0.
- W_CRED=8: coins 200+100 → second coin refunded (vuelto=100), credit 200; finalize → PESADO, vuelto=194.
- Coin 3 and finalize in the same cycle with prior credit 1 → LAVADO, vuelto=0. Coin inserted during lavado → refunded.
- reset=0 during lavado_pesado → next cycle all outputs 0, COBRO; a new purchase works normally.

Source files
------------

// File: rtl/lavadora_pkg.sv
// Shared types and the service-selection helper for the parametrised washer controller.
package lavadora_pkg;

    typedef enum logic [2:0] {
        COBRO  = 3'd0,
        LAVADO = 3'd1,
        PESADO = 3'd2,
        SECADO = 3'd3,
        FIN    = 3'd4
    } estado_t;

    typedef struct packed {
        estado_t     estado;
        logic [31:0] cambio;
    } seleccion_t;

    // Picks the most expensive affordable service; COBRO means the credit is insufficient.
    function automatic seleccion_t seleccionar_servicio(
        input logic [31:0] credito,
        input logic [31:0] p_secado,
        input logic [31:0] p_lavado,
        input logic [31:0] p_pesado
    );
        seleccion_t sel;
        if (credito >= p_pesado) begin
            sel.estado = PESADO;
            sel.cambio = credito - p_pesado;
        end else if (credito >= p_lavado) begin
            sel.estado = LAVADO;
            sel.cambio = credito - p_lavado;
        end else if (credito >= p_secado) begin
            sel.estado = SECADO;
            sel.cambio = credito - p_secado;
        end else begin
            sel.estado = COBRO;
            sel.cambio = 32'd0;
        end
        return sel;
    endfunction

endpackage

// File: rtl/lavadora_param_contador.sv
// Phase timer: loads a remaining-cycle count and counts down to a terminal flag.
module contador_fase #(
    parameter int W_T = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cargar,
    input  logic [W_T-1:0] valor,
    output logic           tc
);

    logic [W_T-1:0] cuenta_r;

    // Down-counter that parks at zero until the next phase reloads it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cuenta_r <= {W_T{1'b0}};
        end else if (cargar) begin
            cuenta_r <= valor;
        end else if (cuenta_r != {W_T{1'b0}}) begin
            cuenta_r <= cuenta_r - {{(W_T-1){1'b0}}, 1'b1};
        end else begin
            cuenta_r <= cuenta_r;
        end
    end

    assign tc = (cuenta_r == {W_T{1'b0}});

endmodule

// File: rtl/lavadora_param.sv
// Coin-operated washer controller: credit accumulation, service selection, change and
// timed wash/dry phases. Every output is a register fed from the next-state logic.
module lavadora_param
    import lavadora_pkg::*;
#(
    parameter int W_CRED   = 8,
    parameter int W_T      = 16,
    parameter int P_SECADO = 2,
    parameter int P_LAVADO = 4,
    parameter int P_PESADO = 6,
    parameter int T_SECADO = 8,
    parameter int T_LAVADO = 10,
    parameter int T_PESADO = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              intro_moneda,
    input  logic [W_CRED-1:0] valor_moneda,
    input  logic              finalizar_pago,
    output logic              lavado,
    output logic              lavado_pesado,
    output logic              secado,
    output logic              insuficiente,
    output logic [W_CRED-1:0] vuelto,
    output logic              vuelto_valido,
    output logic              ocupado,
    output logic              fin
);

    // Timer loads hold T-1 so that a phase spans exactly T cycles including the entry cycle.
    localparam logic [W_T-1:0] CARGA_SECADO = W_T'(T_SECADO - 1);
    localparam logic [W_T-1:0] CARGA_LAVADO = W_T'(T_LAVADO - 1);
    localparam logic [W_T-1:0] CARGA_PESADO = W_T'(T_PESADO - 1);
    localparam logic [31:0]    CRED_MAX     = 32'((64'd1 << W_CRED) - 64'd1);

    estado_t           estado_r, estado_s;
    logic [W_CRED-1:0] credito_r, credito_s;
    logic [W_CRED:0]   suma_s;
    logic              moneda_s, desborde_s;
    logic [W_CRED-1:0] credito_eff_s;
    seleccion_t        sel_s;
    logic [W_CRED-1:0] vuelto_s;
    logic              vuelto_valido_s, insuficiente_s;
    logic              cargar_s;
    logic [W_T-1:0]    carga_s;
    logic              tc_s;

    assign suma_s        = {1'b0, credito_r} + {1'b0, valor_moneda};
    assign moneda_s      = intro_moneda && (valor_moneda != {W_CRED{1'b0}});
    assign desborde_s    = moneda_s && suma_s[W_CRED];
    assign credito_eff_s = (moneda_s && !suma_s[W_CRED]) ? suma_s[W_CRED-1:0] : credito_r;

    contador_fase #(.W_T(W_T)) u_contador (
        .clk    (clk),
        .reset  (reset),
        .cargar (cargar_s),
        .valor  (carga_s),
        .tc     (tc_s)
    );

    // Next-state, credit and pulse logic.
    always_comb begin
        estado_s        = estado_r;
        credito_s       = credito_r;
        vuelto_s        = {W_CRED{1'b0}};
        vuelto_valido_s = 1'b0;
        insuficiente_s  = 1'b0;
        cargar_s        = 1'b0;
        carga_s         = {W_T{1'b0}};
        sel_s           = seleccionar_servicio(32'(credito_eff_s), 32'(P_SECADO),
                                               32'(P_LAVADO), 32'(P_PESADO));
        case (estado_r)
            COBRO: begin
                credito_s = credito_eff_s;
                if (desborde_s) begin
                    vuelto_s        = valor_moneda;
                    vuelto_valido_s = 1'b1;
                end else begin
                    vuelto_s        = {W_CRED{1'b0}};
                end
                // A change pulse takes priority over an overflow refund in the same cycle.
                if (finalizar_pago) begin
                    if (sel_s.estado != COBRO) begin
                        estado_s        = sel_s.estado;
                        credito_s       = {W_CRED{1'b0}};
                        vuelto_s        = (sel_s.cambio > CRED_MAX) ? {W_CRED{1'b1}}
                                                                    : sel_s.cambio[W_CRED-1:0];
                        vuelto_valido_s = 1'b1;
                        cargar_s        = 1'b1;
                        case (sel_s.estado)
                            PESADO:  carga_s = CARGA_PESADO;
                            LAVADO:  carga_s = CARGA_LAVADO;
                            default: carga_s = CARGA_SECADO;
                        endcase
                    end else begin
                        insuficiente_s = 1'b1;
                    end
                end else begin
                    insuficiente_s = 1'b0;
                end
            end
            LAVADO, PESADO: begin
                if (tc_s) begin
                    estado_s = SECADO;
                    cargar_s = 1'b1;
                    carga_s  = CARGA_SECADO;
                end else begin
                    estado_s = estado_r;
                end
            end
            SECADO: begin
                if (tc_s) begin
                    estado_s = FIN;
                end else begin
                    estado_s = SECADO;
                end
            end
            FIN: begin
                estado_s = COBRO;
            end
            default: begin
                estado_s  = COBRO;
                credito_s = {W_CRED{1'b0}};
            end
        endcase
        // Coins arriving while the machine is busy are handed straight back.
        if ((estado_r != COBRO) && intro_moneda) begin
            vuelto_s        = valor_moneda;
            vuelto_valido_s = 1'b1;
        end else begin
            vuelto_valido_s = vuelto_valido_s;
        end
    end

    // State, credit and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            estado_r      <= COBRO;
            credito_r     <= {W_CRED{1'b0}};
            lavado        <= 1'b0;
            lavado_pesado <= 1'b0;
            secado        <= 1'b0;
            insuficiente  <= 1'b0;
            vuelto        <= {W_CRED{1'b0}};
            vuelto_valido <= 1'b0;
            ocupado       <= 1'b0;
            fin           <= 1'b0;
        end else begin
            estado_r      <= estado_s;
            credito_r     <= credito_s;
            lavado        <= (estado_s == LAVADO);
            lavado_pesado <= (estado_s == PESADO);
            secado        <= (estado_s == SECADO);
            insuficiente  <= insuficiente_s;
            vuelto        <= vuelto_s;
            vuelto_valido <= vuelto_valido_s;
            ocupado       <= (estado_s != COBRO);
            fin           <= (estado_s == FIN);
        end
    end

endmodule
